// File: rtl/busca_instrucao.sv
// Instruction fetch stage: drives the instruction memory, fills the IF/ID register
// through a one-entry skid buffer and redirects on jumps and taken branches.
module busca_instrucao #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic [31:0] imemRdata,
   input  logic        imemValid,
   output logic [31:0] instrucao,
   output logic [31:0] pcPlus4,
   output logic        instrValid,
   input  logic        stall,
   input  logic        branch,
   input  logic        zero,
   input  logic        jump,
   input  logic [15:0] imm16,
   input  logic [25:0] jumpIndex,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SKID  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic [31:0] pc_plus4_q;
   logic        instr_valid_q;
   logic [31:0] skid_instr_q;
   logic [31:0] skid_pc4_q;
   logic [31:0] drain_addr_q;

   logic        consume;
   logic        slot_free;
   logic        redirect;
   logic [31:0] jump_target;
   logic [31:0] branch_target;
   logic [31:0] target;
   logic [31:0] pc_next_seq;

   // Handshake toward decode: IF/ID is offered while instrValid=1 and is taken on a
   // rising edge where stall=0; memory side, imemReq/imemAddr stay put until imemValid.
   assign consume   = instr_valid_q & ~stall;
   assign slot_free = ~instr_valid_q | ~stall;
   assign redirect  = consume & (jump | (branch & zero));

   assign jump_target   = {pc_plus4_q[31:28], jumpIndex, 2'b00};
   assign branch_target = pc_plus4_q + {{14{imm16[15]}}, imm16, 2'b00};
   assign target        = jump ? jump_target : branch_target;
   assign pc_next_seq   = pc_q + 32'd4;

   // DRAIN keeps presenting the abandoned address until its response is swallowed.
   assign imemReq  = ~rst & ((state_q == FETCH) | (state_q == DRAIN));
   assign imemAddr = (state_q == DRAIN) ? drain_addr_q : pc_q;

   assign instrucao  = instr_q;
   assign pcPlus4    = pc_plus4_q;
   assign instrValid = instr_valid_q;
   assign state_o    = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pc_q          <= RESET_VECTOR;
         instr_q       <= 32'd0;
         pc_plus4_q    <= 32'd0;
         instr_valid_q <= 1'b0;
         skid_instr_q  <= 32'd0;
         skid_pc4_q    <= 32'd0;
         drain_addr_q  <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= FETCH;
            end

            FETCH: begin
               if (redirect) begin
                  pc_q          <= target;
                  instr_valid_q <= 1'b0;
                  if (!imemValid) begin
                     drain_addr_q <= pc_q;
                     state_q      <= DRAIN;
                  end
               end else if (imemValid) begin
                  pc_q <= pc_next_seq;
                  if (slot_free) begin
                     instr_q       <= imemRdata;
                     pc_plus4_q    <= pc_next_seq;
                     instr_valid_q <= 1'b1;
                  end else begin
                     skid_instr_q <= imemRdata;
                     skid_pc4_q   <= pc_next_seq;
                     state_q      <= SKID;
                  end
               end else if (consume) begin
                  instr_valid_q <= 1'b0;
               end
            end

            SKID: begin
               if (redirect) begin
                  pc_q          <= target;
                  instr_valid_q <= 1'b0;
                  skid_instr_q  <= 32'd0;
                  skid_pc4_q    <= 32'd0;
                  state_q       <= FETCH;
               end else if (slot_free) begin
                  instr_q       <= skid_instr_q;
                  pc_plus4_q    <= skid_pc4_q;
                  instr_valid_q <= 1'b1;
                  state_q       <= FETCH;
               end
            end

            DRAIN: begin
               if (imemValid) begin
                  state_q <= FETCH;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: a latency-programmable memory model feeds the
// fetch stage while a scoreboard checks every word consumed by decode.
module tb_busca_instrucao;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_SKID  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic [31:0] imemRdata;
   logic        imemValid;
   logic [31:0] instrucao;
   logic [31:0] pcPlus4;
   logic        instrValid;
   logic        stall;
   logic        branch;
   logic        zero;
   logic        jump;
   logic [15:0] imm16;
   logic [25:0] jumpIndex;
   logic [1:0]  state_o;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          lat      = 1;
   int          wait_cnt = 0;
   logic [63:0] exp_q[$];

   busca_instrucao #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clk       (clk),
      .rst       (rst),
      .imemReq   (imemReq),
      .imemAddr  (imemAddr),
      .imemRdata (imemRdata),
      .imemValid (imemValid),
      .instrucao (instrucao),
      .pcPlus4   (pcPlus4),
      .instrValid(instrValid),
      .stall     (stall),
      .branch    (branch),
      .zero      (zero),
      .jump      (jump),
      .imm16     (imm16),
      .jumpIndex (jumpIndex),
      .state_o   (state_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
   endfunction

   // Memory model: answers after lat cycles of continuous request (lat=1 is same cycle).
   always @(posedge clk) begin
      if (rst || !imemReq || imemValid) wait_cnt <= 0;
      else                              wait_cnt <= wait_cnt + 1;
   end
   assign imemValid = imemReq && (wait_cnt >= lat - 1);
   assign imemRdata = imemValid ? mem_word(imemAddr) : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every word decode takes must be the next expected {pcPlus4, instr}.
   always @(negedge clk) begin
      if (!rst && instrValid && !stall) begin
         if (exp_q.size() != 0) chk64("sb_word", {pcPlus4, instrucao}, exp_q.pop_front());
         else                   chk64("sb_extra", {pcPlus4, instrucao}, 64'bx);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seq(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({start + 32'(4 * i) + 32'd4, mem_word(start + 32'(4 * i))});
      end
   endtask

   task automatic clear_ctrl();
      branch    = 1'b0;
      zero      = 1'b0;
      jump      = 1'b0;
      imm16     = 16'h0000;
      jumpIndex = 26'h0;
   endtask

   task automatic do_reset(input string tag);
      rst   = 1'b1;
      stall = 1'b0;
      clear_ctrl();
      tick();
      tick();
      exp_q.delete();
      chk({tag, "_rst_state"}, {30'd0, state_o}, {30'd0, S_IDLE});
      chk({tag, "_rst_valid"}, {31'd0, instrValid}, 32'd0);
      chk({tag, "_rst_instr"}, instrucao, 32'd0);
      chk({tag, "_rst_pc4"}, pcPlus4, 32'd0);
      chk({tag, "_rst_req"}, {31'd0, imemReq}, 32'd0);
   endtask

   task automatic wait_pc4(input logic [31:0] v, input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (instrValid && pcPlus4 == v) found = 1'b1;
         else tick();
      end
      chk(tag, {31'd0, found}, 32'd1);
   endtask

   task automatic wait_empty(input string tag);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      clear_ctrl();

      // Same-cycle memory, no stalls: one instruction per cycle.
      lat = 1;
      do_reset("p1");
      push_seq(32'h0, 6);
      rst = 1'b0;
      chk("p1_idle_req", {31'd0, imemReq}, 32'd0);
      tick();
      chk("p1_addr0", imemAddr, 32'h0);
      chk("p1_req0", {31'd0, imemReq}, 32'd1);
      chk("p1_valid0", {31'd0, instrValid}, 32'd0);
      tick();
      chk("p1_addr4", imemAddr, 32'h4);
      chk("p1_valid1", {31'd0, instrValid}, 32'd1);
      chk("p1_pc4_4", pcPlus4, 32'h4);
      tick();
      chk("p1_addr8", imemAddr, 32'h8);
      chk("p1_pc4_8", pcPlus4, 32'h8);
      tick();
      chk("p1_pc4_12", pcPlus4, 32'hC);
      wait_empty("p1_empty");

      // Three-cycle memory: address held three cycles, instrValid pulses once per word.
      lat = 3;
      do_reset("p2");
      push_seq(32'h0, 4);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 3; j++) begin
            tick();
            chk("p2_addr", imemAddr, 32'(4 * k));
            chk("p2_valid", {31'd0, instrValid}, {31'd0, (k > 0 && j == 0)});
         end
      end
      wait_empty("p2_empty");

      // Stall while a response lands: word parks in the skid buffer.
      lat = 1;
      do_reset("p3");
      push_seq(32'h0, 8);
      rst = 1'b0;
      wait_pc4(32'h8, "p3_wait");
      stall = 1'b1;
      chk("p3_pre_state", {30'd0, state_o}, {30'd0, S_FETCH});
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("p3_skid_state", {30'd0, state_o}, {30'd0, S_SKID});
         chk("p3_skid_req", {31'd0, imemReq}, 32'd0);
         chk("p3_hold_instr", instrucao, mem_word(32'h4));
         chk("p3_hold_pc4", pcPlus4, 32'h8);
      end
      stall = 1'b0;
      tick();
      chk("p3_skid_out_pc4", pcPlus4, 32'hC);
      chk("p3_skid_out_instr", instrucao, mem_word(32'h8));
      chk("p3_skid_out_valid", {31'd0, instrValid}, 32'd1);
      chk("p3_back_fetch", {30'd0, state_o}, {30'd0, S_FETCH});
      wait_empty("p3_empty");

      // Jump with a same-cycle response in flight; jump wins over a taken branch.
      lat = 1;
      do_reset("p4");
      push_seq(32'h0, 2);
      push_seq(32'h40, 3);
      rst = 1'b0;
      wait_pc4(32'h8, "p4_wait");
      chk("p4_inflight_addr", imemAddr, 32'h8);
      jump = 1'b1;
      jumpIndex = 26'h0000010;
      branch = 1'b1;
      zero = 1'b1;
      imm16 = 16'h1234;
      tick();
      clear_ctrl();
      chk("p4_jump_addr", imemAddr, 32'h40);
      chk("p4_jump_valid", {31'd0, instrValid}, 32'd0);
      chk("p4_jump_state", {30'd0, state_o}, {30'd0, S_FETCH});
      wait_empty("p4_empty");

      // Taken branch with an outstanding slow request: DRAIN then fetch target.
      lat = 3;
      do_reset("p5");
      push_seq(32'h0, 1);
      push_seq(32'h20, 2);
      rst = 1'b0;
      wait_pc4(32'h4, "p5_wait");
      branch = 1'b1;
      zero = 1'b1;
      imm16 = 16'h0007;
      tick();
      clear_ctrl();
      chk("p5_drain_state", {30'd0, state_o}, {30'd0, S_DRAIN});
      chk("p5_drain_addr", imemAddr, 32'h4);
      chk("p5_drain_req", {31'd0, imemReq}, 32'd1);
      chk("p5_drain_valid", {31'd0, instrValid}, 32'd0);
      tick();
      chk("p5_drain_state2", {30'd0, state_o}, {30'd0, S_DRAIN});
      chk("p5_drain_addr2", imemAddr, 32'h4);
      tick();
      chk("p5_target_state", {30'd0, state_o}, {30'd0, S_FETCH});
      chk("p5_target_addr", imemAddr, 32'h20);
      wait_empty("p5_empty");

      // Reset arriving mid-DRAIN.
      lat = 3;
      do_reset("p6");
      push_seq(32'h0, 1);
      rst = 1'b0;
      wait_pc4(32'h4, "p6_wait");
      jump = 1'b1;
      jumpIndex = 26'h0000020;
      tick();
      clear_ctrl();
      chk("p6_drain_state", {30'd0, state_o}, {30'd0, S_DRAIN});
      chk("p6_sb_empty", 32'(exp_q.size()), 32'd0);
      rst = 1'b1;
      tick();
      chk("p6_rst_state", {30'd0, state_o}, {30'd0, S_IDLE});
      chk("p6_rst_valid", {31'd0, instrValid}, 32'd0);
      chk("p6_rst_req", {31'd0, imemReq}, 32'd0);
      rst = 1'b0;
      push_seq(32'h0, 2);
      chk("p6_idle_req", {31'd0, imemReq}, 32'd0);
      tick();
      chk("p6_restart_state", {30'd0, state_o}, {30'd0, S_FETCH});
      chk("p6_restart_addr", imemAddr, 32'h0);
      wait_empty("p6_empty");

      // Backward branch taken, then the same branch not taken.
      lat = 1;
      do_reset("p7");
      push_seq(32'h0, 4);
      push_seq(32'hC, 2);
      push_seq(32'h14, 3);
      rst = 1'b0;
      wait_pc4(32'h10, "p7_wait_taken");
      branch = 1'b1;
      zero = 1'b1;
      imm16 = 16'hFFFF;
      tick();
      clear_ctrl();
      chk("p7_taken_addr", imemAddr, 32'hC);
      chk("p7_taken_valid", {31'd0, instrValid}, 32'd0);
      wait_pc4(32'h14, "p7_wait_nt");
      branch = 1'b1;
      zero = 1'b0;
      imm16 = 16'hFFFF;
      tick();
      clear_ctrl();
      chk("p7_nt_addr", imemAddr, 32'h18);
      chk("p7_nt_pc4", pcPlus4, 32'h18);
      chk("p7_nt_valid", {31'd0, instrValid}, 32'd1);
      wait_empty("p7_empty");

      rst = 1'b1;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/busca_instrucao.md
BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  system clock; the block uses one clock, rising edge only.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port imemReq  output  1  instruction-memory request.
REQ-005 SHALL have port imemAddr  output  32  byte address of the requested word.
REQ-006 SHALL have port imemRdata  input  32  instruction word, valid only when imemValid=1.
REQ-007 SHALL have port imemValid  input  1  single-cycle response pulse; may arrive the same cycle as imemReq.
REQ-008 SHALL have port instrucao  output  32  IF/ID instruction; bits [31:26] drive the control unit opcode.
REQ-009 SHALL have port pcPlus4  output  32  IF/ID address of instrucao plus 4.
REQ-010 SHALL have port instrValid  output  1  IF/ID holds a valid instruction.
REQ-011 SHALL have port stall  input  1  decode cannot consume IF/ID this cycle.
REQ-012 SHALL have port branch, zero, jump  input  1 each  control-unit/ALU results for the instruction in IF/ID.
REQ-013 SHALL have port imm16  input  16  branch offset field of the instruction in IF/ID.
REQ-014 SHALL have port jumpIndex  input  26  jump target field of the instruction in IF/ID.

Function
REQ-015 SHALL hold the FSM in one of four states: IDLE, FETCH, SKID or DRAIN.
REQ-016 SHALL define consume = instrValid & !stall and slotFree = !instrValid | !stall.
REQ-017 SHALL define redirect = consume & (jump | (branch & zero)).
REQ-018 SHALL pick the target by priority jump over branch.
REQ-019 SHALL compute jump target as {pcPlus4[31:28], jumpIndex, 2'b00}.
REQ-020 SHALL compute branch target as pcPlus4 + (sign-extended imm16 << 2), modulo 2^32.
REQ-021 SHALL assert imemReq only in FETCH and DRAIN.
REQ-022 SHALL drive imemAddr = pc in FETCH; in DRAIN it SHALL keep the address of the outstanding request stable until imemValid.
REQ-023 In IDLE, the block SHALL drive imemReq=0, ignore imemValid, and go to FETCH on the next cycle.
REQ-024 In FETCH with imemValid, slotFree and no redirect, at the next edge it SHALL load instrucao<=imemRdata, pcPlus4<=pc+4, instrValid<=1 and pc<=pc+4, and stay in FETCH (throughput 1 instruction/cycle).
REQ-025 In FETCH with imemValid, !slotFree and no redirect, it SHALL capture the word and pc+4 into the skid register, set pc<=pc+4 and go to SKID.
REQ-026 In SKID, when slotFree and no redirect, it SHALL move the skid contents into IF/ID with instrValid<=1 and go to FETCH.
REQ-027 Whenever consume is true and no new word is loaded that cycle, it SHALL set instrValid<=0.
REQ-028 Redirect SHALL have top priority: pc<=target, instrValid<=0, skid contents discarded.
REQ-029 Redirect in FETCH without imemValid SHALL go to DRAIN; with imemValid the same cycle, the returned word SHALL be dropped and the state SHALL stay FETCH.
REQ-030 Redirect in SKID SHALL go to FETCH.
REQ-031 In DRAIN, on imemValid the word SHALL be discarded and the state SHALL go to FETCH, fetching from the redirected pc.
REQ-032 While stall=1 with instrValid=1, instrucao and pcPlus4 SHALL hold their values.
REQ-033 Branch, jump, zero, imm16 and jumpIndex SHALL be ignored unless consume=1.

Reset
REQ-034 At a rising edge with rst=1, the block SHALL set pc<=RESET_VECTOR, state<=IDLE, instrValid<=0, instrucao<=0, pcPlus4<=0 and clear the skid register, regardless of state, including mid-request or mid-DRAIN.
REQ-035 While rst=1, imemReq SHALL be 0.
REQ-036 The instruction memory SHALL be reset by the same rst, so no response returns after reset for a pre-reset request.

Verification
REQ-037 Reset, then imemValid same-cycle with stall=0 -> imemAddr 0,4,8 on consecutive cycles; instrValid=1 from the 3rd cycle after reset release; pcPlus4 = 4, 8, 12.
REQ-038 Memory latency 3 cycles -> imemAddr held stable 3 cycles per word; instrValid pulses for 1 cycle per word.
REQ-039 stall=1 for 4 cycles while a response arrives -> state SKID, imemReq=0, instrucao unchanged; on stall release the skid word appears next cycle with no loss or duplication.
REQ-040 jump=1, jumpIndex=26'h0000010, pcPlus4=32'h0000_0008 -> next imemAddr=32'h0000_0040 and the in-flight word is discarded (DRAIN if outstanding).
REQ-041 Backward branch: beq with zero=1, imm16=16'hFFFF, pcPlus4=32'h0000_0010 -> target 32'h0000_000C; with zero=0 -> sequential fetch continues.
REQ-042 rst asserted during DRAIN -> next cycle state IDLE, instrValid=0, imemReq=0; fetch restarts at RESET_VECTOR.
